// File: rtl/instr_fetch_reg_if.sv
// Instruction-memory read port for the fetch stage.
// The request side holds im_req/im_addr until it sees im_ack.
interface instr_fetch_reg_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_ack,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_ack,
    output im_rdata
  );
endinterface

// File: rtl/instr_fetch_reg.sv
// Multi-cycle MIPS fetch stage and instruction register.
// Issues one memory read per fetch_start and holds the fetched word.
module instr_fetch_reg #(
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_start,
  input  logic [31:0]               pc_in,
  instr_fetch_reg_if.master         im,
  output logic                      busy,
  output logic                      ir_valid,
  output logic                      fetch_err,
  output logic                      misaligned,
  output logic [31:0]               instr,
  output logic [5:0]                op,
  output logic [4:0]                rs,
  output logic [4:0]                rt,
  output logic [4:0]                rd,
  output logic [4:0]                shamt,
  output logic [5:0]                funct,
  output logic [15:0]               imm16,
  output logic [25:0]               addr26
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ERR
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      instr      <= RESET_INSTR;
      im.im_req  <= 1'b0;
      im.im_addr <= 32'h0;
      busy       <= 1'b0;
      ir_valid   <= 1'b0;
      fetch_err  <= 1'b0;
      misaligned <= 1'b0;
      cnt        <= 8'h0;
    end else begin
      ir_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_start) begin
            if (pc_in[1:0] == 2'b00) begin
              state      <= REQ;
              im.im_req  <= 1'b1;
              im.im_addr <= pc_in;
              busy       <= 1'b1;
              cnt        <= 8'h0;
            end else begin
              state      <= ERR;
              fetch_err  <= 1'b1;
              misaligned <= 1'b1;
            end
          end
        end
        REQ: begin
          // an ack on the last allowed cycle still counts as success
          if (im.im_ack) begin
            state     <= IDLE;
            instr     <= im.im_rdata;
            ir_valid  <= 1'b1;
            im.im_req <= 1'b0;
            busy      <= 1'b0;
          end else if (cnt == LAST) begin
            state     <= ERR;
            fetch_err <= 1'b1;
            im.im_req <= 1'b0;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        ERR: begin
          im.im_req <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state <= ERR;
        end
      endcase
    end
  end

  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];
  assign addr26 = instr[25:0];

endmodule
